// File: rtl/uart_pkg.sv
// Types and line-level constants shared by the UART TX and RX blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Line levels; the RX side samples against the same values.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; head is the oldest entry (show-ahead).
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage is not reset; stale entries are never visible past level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming UART transmitter: FIFO-buffered bytes, configurable frame, tick-paced.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int      LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int      BW  = $clog2(DATA_W);
  localparam parity_t PAR = parity_t'(2'(PARITY));

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_idx;
  logic              parity_acc;
  logic [1:0]        stop_cnt;

  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              start_tick;
  logic [LW-1:0]     level_nxt;

  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  // The final stop tick doubles as an idle tick so frames can run back-to-back.
  assign start_tick = baud_tick &&
                      ((state == ST_IDLE) || (state == ST_STOP && stop_cnt == 2'(STOP_BITS)));
  assign pop        = start_tick && !empty;
  assign level_nxt  = fifo_level + LW'(push) - LW'(pop);

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .head  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Frame sequencer: every tx change happens on a baud tick; busy tracks next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= LINE_IDLE;
      busy       <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_acc <= 1'b0;
      stop_cnt   <= '0;
    end else begin
      busy <= (state != ST_IDLE) || (level_nxt != '0);
      if (start_tick) begin
        if (!empty) begin
          shift_reg  <= head;
          tx         <= LINE_START;
          bit_idx    <= '0;
          parity_acc <= 1'b0;
          state      <= ST_DATA;
          busy       <= 1'b1;
        end else begin
          tx    <= LINE_IDLE;
          state <= ST_IDLE;
          busy  <= (level_nxt != '0);
        end
      end else if (baud_tick) begin
        case (state)
          ST_DATA: begin
            tx         <= shift_reg[0];
            shift_reg  <= shift_reg >> 1;
            parity_acc <= parity_acc ^ shift_reg[0];
            bit_idx    <= bit_idx + 1'b1;
            if (bit_idx == BW'(DATA_W - 1)) begin
              state    <= (PAR == PAR_NONE) ? ST_STOP : ST_PARITY;
              stop_cnt <= '0;
            end
          end
          ST_PARITY: begin
            tx       <= (PAR == PAR_ODD) ? ~parity_acc : parity_acc;
            state    <= ST_STOP;
            stop_cnt <= '0;
          end
          ST_STOP: begin
            tx       <= LINE_STOP;
            stop_cnt <= stop_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench: five frame formats side by side against a bit-queue line model.
module tb_uart_tx_stream;
  localparam int N     = 5;
  localparam int DEPTH = 8;
  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 5N1
  localparam int DW_A  [N] = '{8, 8, 8, 8, 5};
  localparam int PAR_A [N] = '{0, 1, 2, 0, 0};
  localparam int SB_A  [N] = '{1, 1, 1, 2, 1};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         baud_tick = 1'b0;
  logic [7:0]   in_data [N];
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N-1:0] tx;
  logic [N-1:0] busy;
  logic [3:0]   fifo_level [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DW = DW_A[g];
    uart_tx_stream #(
      .DATA_W(DW), .PARITY(PAR_A[g]), .STOP_BITS(SB_A[g]), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .in_data    (in_data[g][DW-1:0]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .fifo_level (fifo_level[g])
    );
  end

  // Model: queued bytes, pending line bits of the current frame, observed line per tick.
  byte unsigned bq   [N][$];
  bit           lq   [N][$];
  bit           seen [N][$];
  bit           act  [N];
  bit           ex_tx[N];
  int           n_chk  = 0;
  int           n_fail = 0;

  task automatic check(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      lq[i].delete();
      act[i]   = 1'b0;
      ex_tx[i] = 1'b1;
    end
  endtask

  // Advance the model across one clock edge using pre-edge inputs.
  task automatic model_edge(input bit tk);
    for (int i = 0; i < N; i++) begin
      bit           acc;
      bit           p;
      byte unsigned b;
      acc = in_valid[i] && (bq[i].size() < DEPTH);
      if (tk) begin
        if (lq[i].size() == 0) begin
          if (bq[i].size() != 0) begin
            b = bq[i].pop_front();
            act[i] = 1'b1;
            p = 1'b0;
            lq[i].push_back(1'b0);
            for (int k = 0; k < DW_A[i]; k++) begin
              lq[i].push_back(b[k]);
              p ^= b[k];
            end
            if (PAR_A[i] == 1) lq[i].push_back(p);
            else if (PAR_A[i] == 2) lq[i].push_back(!p);
            for (int k = 0; k < SB_A[i]; k++) lq[i].push_back(1'b1);
          end else begin
            act[i] = 1'b0;
          end
        end
        ex_tx[i] = (lq[i].size() != 0) ? lq[i].pop_front() : 1'b1;
      end
      if (acc) bq[i].push_back(in_data[i]);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < N; i++) begin
      check("tx",         i, 16'(tx[i]),         16'(ex_tx[i]));
      check("busy",       i, 16'(busy[i]),       16'(act[i] || bq[i].size() != 0));
      check("fifo_level", i, 16'(fifo_level[i]), 16'(bq[i].size()));
      check("in_ready",   i, 16'(in_ready[i]),   16'(bq[i].size() != DEPTH));
    end
  endtask

  task automatic step(input bit tk);
    baud_tick = tk;
    @(posedge clk);
    model_edge(tk);
    #1;
    compare();
    if (tk) for (int i = 0; i < N; i++) seen[i].push_back(tx[i]);
    baud_tick = 1'b0;
  endtask

  task automatic tick();
    step(1'b1);
    repeat (3) step(1'b0);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N; i++) seen[i].delete();
  endtask

  function automatic logic [15:0] pack(input int i, input int s, input int n);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v = {v[14:0], seen[i][s+k]};
    return v;
  endfunction

  task automatic check_reset_values(input string nm);
    for (int i = 0; i < N; i++) begin
      check({nm, "_tx"},    i, 16'(tx[i]),         16'h1);
      check({nm, "_busy"},  i, 16'(busy[i]),       16'h0);
      check({nm, "_ready"}, i, 16'(in_ready[i]),   16'h1);
      check({nm, "_level"}, i, 16'(fifo_level[i]), 16'h0);
    end
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check("rst_async_tx", i, 16'(tx[i]), 16'h1);
    model_reset();
    in_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("post_rst");
    compare();
  endtask

  initial begin
    logic [7:0] polo [5];
    logic [7:0] d;
    polo = '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0A};
    in_valid = '0;
    for (int i = 0; i < N; i++) in_data[i] = 8'h00;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Idle line for 20 ticks
    clear_seen();
    repeat (20) tick();
    for (int i = 0; i < N; i++) begin
      check("idle20_a", i, pack(i, 0, 16), 16'hFFFF);
      check("idle20_b", i, pack(i, 16, 4), 16'h000F);
    end

    // One frame on every format; 8N2 gets the five-byte string
    clear_seen();
    in_data  = '{8'h50, 8'h4F, 8'h4F, 8'h50, 8'hFF};
    in_valid = 5'b11111;
    step(1'b0);
    in_valid = 5'b01000;
    for (int k = 1; k < 5; k++) begin
      in_data[3] = polo[k];
      step(1'b0);
    end
    in_valid = '0;
    repeat (60) tick();
    check("frame_8n1", 0, pack(0, 0, 10), 16'h015);
    check("frame_8e1", 1, pack(1, 0, 11), 16'h3CB);
    check("frame_8o1", 2, pack(2, 0, 11), 16'h3C9);
    check("frame_5n1", 4, pack(4, 0, 8),  16'h07F);
    for (int f = 0; f < 5; f++) begin
      d = '0;
      for (int k = 0; k < 8; k++) d[k] = seen[3][11*f + 1 + k];
      check("polo_start", f, 16'(seen[3][11*f]),      16'h0);
      check("polo_byte",  f, 16'(d),                  16'(polo[f]));
      check("polo_stops", f, pack(3, 11*f + 9, 2),    16'h3);
    end
    check("polo_idle_after", 3, 16'(seen[3][55]), 16'h1);
    for (int i = 0; i < N; i++) check("busy_done", i, 16'(busy[i]), 16'h0);

    // Push in the same cycle as an idle tick: waits one tick period
    clear_seen();
    in_data[0] = 8'hA5;
    in_valid   = 5'b00001;
    step(1'b1);
    in_valid   = '0;
    repeat (3) step(1'b0);
    repeat (11) tick();
    check("late_push", 0, pack(0, 0, 12), 16'hA97);

    // Fill inst 0's FIFO with no ticks, ninth byte held off
    clear_seen();
    in_valid = 5'b00001;
    for (int p = 0; p < 9; p++) begin
      in_data[0] = 8'h10 + 8'(p);
      step(1'b0);
      if (p == 7) begin
        check("full_level", 0, 16'(fifo_level[0]), 16'h8);
        check("full_ready", 0, 16'(in_ready[0]),   16'h0);
      end
    end
    check("held_level", 0, 16'(fifo_level[0]), 16'h8);
    step(1'b1);
    check("pop_level", 0, 16'(fifo_level[0]), 16'h7);
    check("pop_ready", 0, 16'(in_ready[0]),   16'h1);
    step(1'b0);
    in_valid = '0;
    check("refill_level", 0, 16'(fifo_level[0]), 16'h8);
    repeat (2) step(1'b0);
    repeat (95) tick();
    d = '0;
    for (int k = 0; k < 8; k++) d[k] = seen[0][80 + 1 + k];
    check("ninth_byte", 0, 16'(d), 16'h18);
    check("drain_busy", 0, 16'(busy[0]), 16'h0);

    // Reset in the third data bit of the 5N1 frame, with a byte still queued
    clear_seen();
    in_data[0] = 8'h00;
    in_data[4] = 8'hFF;
    in_valid   = 5'b10001;
    step(1'b0);
    in_data[4] = 8'h12;
    in_valid   = 5'b10000;
    step(1'b0);
    in_valid   = '0;
    repeat (3) tick();
    step(1'b1);
    check("pre_rst_level", 4, 16'(fifo_level[4]), 16'h1);
    check("pre_rst_tx",    0, 16'(tx[0]),         16'h0);
    pulse_rst();
    clear_seen();
    repeat (20) tick();
    for (int i = 0; i < N; i++) check("post_rst_idle", i, pack(i, 4, 16), 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
